// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port single-cycle data memory arbiter with starvation override.
// Define DMEM_ARB_RR_EN for round-robin conflict resolution; the default is fixed priority with port 0 winning.
module dmem_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 9,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p0_gnt,
  output logic              p1_gnt,
  output logic              p0_rvalid,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data
);
  typedef enum logic [1:0] {OWN_NONE, OWN_P0, OWN_P1} own_e;
  own_e              own_q, own_d;
  logic [7:0]        wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0] p0_hold_q, p0_hold_d, p1_hold_q, p1_hold_d;
  logic              force_p1, pick_p1;
`ifdef DMEM_ARB_RR_EN
  logic              ptr_q, ptr_d;
`endif
  always_comb begin
    force_p1 = p1_req && wait_cnt_q == 8'(MAX_WAIT);
`ifdef DMEM_ARB_RR_EN
    pick_p1 = force_p1 || (p1_req && (!p0_req || ptr_q));
`else
    pick_p1 = force_p1 || (p1_req && !p0_req);
`endif
    p1_gnt      = !reset && pick_p1;
    p0_gnt      = !reset && p0_req && !pick_p1;
    mem_wr      = p0_gnt ? p0_we : p1_gnt && p1_we;
    mem_rd      = p0_gnt ? !p0_we : p1_gnt && !p1_we;
    mem_addr    = p0_gnt ? p0_addr : p1_gnt ? p1_addr : '0;
    mem_wr_data = p0_gnt ? p0_wdata : p1_gnt ? p1_wdata : '0;
    own_d       = !mem_rd ? OWN_NONE : p1_gnt ? OWN_P1 : OWN_P0;
    // rvalid is gated by reset so a read granted just before reset never returns
    p0_rvalid   = !reset && own_q == OWN_P0;
    p1_rvalid   = !reset && own_q == OWN_P1;
    p0_rdata    = reset ? '0 : p0_rvalid ? mem_rd_data : p0_hold_q;
    p1_rdata    = reset ? '0 : p1_rvalid ? mem_rd_data : p1_hold_q;
    p0_hold_d   = p0_rdata;
    p1_hold_d   = p1_rdata;
    wait_cnt_d  = !(p1_req && !p1_gnt) ? 8'd0 :
                  wait_cnt_q == 8'(MAX_WAIT) ? wait_cnt_q : wait_cnt_q + 8'd1;
`ifdef DMEM_ARB_RR_EN
    ptr_d       = (ptr_q ? p1_gnt : p0_gnt) ? !ptr_q : ptr_q;
`endif
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      own_q      <= OWN_NONE;
      wait_cnt_q <= '0;
      p0_hold_q  <= '0;
      p1_hold_q  <= '0;
    end else begin
      own_q      <= own_d;
      wait_cnt_q <= wait_cnt_d;
      p0_hold_q  <= p0_hold_d;
      p1_hold_q  <= p1_hold_d;
    end
  end
`ifdef DMEM_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= 1'b0;
    else ptr_q <= ptr_d;
  end
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter with a one-cycle-latency memory model.
module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [8:0]  p0_addr, p1_addr;
  logic [31:0] p0_wdata, p1_wdata;
  logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_wr, mem_rd;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wr_data, mem_rd_data;
  logic [31:0] mem [0:511];
  int          errors = 0;
  int          checks = 0;
  logic        prev_p0, prev_p1, exp_p1;

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
    .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
    .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr] <= mem_wr_data;
    mem_rd_data <= mem_rd ? mem[mem_addr] : 32'h0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_req(input logic r0, input logic w0, input logic [8:0] a0, input logic [31:0] d0,
                         input logic r1, input logic w1, input logic [8:0] a1, input logic [31:0] d1);
    p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'h0;
    mem[5] = 32'hDEADBEEF;
    mem[3] = 32'h00000333;
    reset = 1'b1;
    set_req(1, 0, 9'h003, 0, 1, 0, 9'h004, 0);
    repeat (2) begin
      tick();
      #1;
      check("rst_gnt", {30'd0, p0_gnt, p1_gnt}, 0);
      check("rst_strobe", {30'd0, mem_wr, mem_rd}, 0);
      check("rst_addr", {23'd0, mem_addr}, 0);
      check("rst_rvalid", {30'd0, p0_rvalid, p1_rvalid}, 0);
      check("rst_rdata", p0_rdata | p1_rdata, 0);
    end
    tick();
    reset = 1'b0;
    #1;
    check("first_gnt", {30'd0, p0_gnt, p1_gnt}, 2'b10);
    check("first_addr", {23'd0, mem_addr}, 32'h003);
    tick();
    set_req(1, 0, 9'h005, 0, 0, 0, 0, 0);
    #1;
    check("first_rvalid", {30'd0, p0_rvalid, p1_rvalid}, 2'b10);
    check("first_rdata", p0_rdata, 32'h00000333);
    check("rd_gnt", {30'd0, p0_gnt, p1_gnt}, 2'b10);
    check("rd_strobe", {30'd0, mem_wr, mem_rd}, 2'b01);
    check("rd_addr", {23'd0, mem_addr}, 32'h005);
    tick();
    set_req(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("rd_rvalid", {30'd0, p0_rvalid, p1_rvalid}, 2'b10);
    check("rd_rdata", p0_rdata, 32'hDEADBEEF);
    check("idle_strobe", {29'd0, mem_wr, mem_rd, p0_gnt | p1_gnt}, 0);
    tick();
    #1;
    check("rd_rvalid_drop", {30'd0, p0_rvalid, p1_rvalid}, 0);
    check("rd_rdata_hold", p0_rdata, 32'hDEADBEEF);
    tick();
    set_req(1, 1, 9'h010, 32'h12345678, 0, 0, 0, 0);
    #1;
    check("wr_gnt", {30'd0, p0_gnt, p1_gnt}, 2'b10);
    check("wr_strobe", {30'd0, mem_wr, mem_rd}, 2'b10);
    check("wr_addr", {23'd0, mem_addr}, 32'h010);
    check("wr_data", mem_wr_data, 32'h12345678);
    tick();
    set_req(0, 0, 0, 0, 1, 0, 9'h010, 0);
    #1;
    check("b2b_p1_gnt", {30'd0, p0_gnt, p1_gnt}, 2'b01);
    check("b2b_strobe", {30'd0, mem_wr, mem_rd}, 2'b01);
    check("wr_no_rvalid", {30'd0, p0_rvalid, p1_rvalid}, 0);
    tick();
    set_req(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("b2b_rvalid", {30'd0, p0_rvalid, p1_rvalid}, 2'b01);
    check("b2b_p1_rdata", p1_rdata, 32'h12345678);
    check("b2b_p0_hold", p0_rdata, 32'hDEADBEEF);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_req(1, 0, 9'h001, 0, 1, 0, 9'h002, 0);
    #1;
    prev_p0 = 1'b0;
    prev_p1 = 1'b0;
`ifdef DMEM_ARB_RR_EN
    for (int i = 0; i < 6; i++) begin
      exp_p1 = (i % 2) == 1;
`else
    for (int i = 0; i < 10; i++) begin
      exp_p1 = i == 8;
`endif
      check($sformatf("arb_gnt_%0d", i), {30'd0, p0_gnt, p1_gnt}, {30'd0, !exp_p1, exp_p1});
      check($sformatf("arb_rvalid_%0d", i), {30'd0, p0_rvalid, p1_rvalid}, {30'd0, prev_p0, prev_p1});
      prev_p0 = !exp_p1;
      prev_p1 = exp_p1;
      tick();
      #1;
    end
    set_req(0, 0, 0, 0, 1, 0, 9'h010, 0);
    #1;
    check("rst_rd_gnt", {30'd0, p0_gnt, p1_gnt, 1'b0} >> 1, 2'b01);
    tick();
    reset = 1'b1;
    set_req(1, 0, 9'h005, 0, 1, 0, 9'h010, 0);
    #1;
    check("rst_rd_rvalid", {30'd0, p0_rvalid, p1_rvalid}, 0);
    check("rst_rd_rdata", p0_rdata | p1_rdata, 0);
    check("rst_rd_gnt_off", {30'd0, p0_gnt, p1_gnt}, 0);
    check("rst_rd_outs", {mem_wr, mem_rd, mem_addr} | {11'd0, mem_wr_data[20:0]} | {11'd0, mem_wr_data[31:11]}, 0);
    tick();
    reset = 1'b0;
    set_req(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("post_rst_rvalid", {30'd0, p0_rvalid, p1_rvalid}, 0);
    check("post_rst_rdata", p0_rdata | p1_rdata, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
